// File: rtl/zoom_pkg.sv
// Shared definitions for the zoom datapath: scan FSM state encoding and
// default coordinate widths used by the 2-D scan counter and its axis counters.
package zoom_pkg;

    localparam int LARG_W_PADRAO  = 10;
    localparam int ALT_W_PADRAO   = 10;
    localparam int PASSO_W_PADRAO = 3;

    localparam logic [1:0] EST_OCIOSO   = 2'd0;
    localparam logic [1:0] EST_VARRENDO = 2'd1;
    localparam logic [1:0] EST_FIM      = 2'd2;

    typedef enum logic [1:0] {
        OCIOSO   = EST_OCIOSO,
        VARRENDO = EST_VARRENDO,
        FIM      = EST_FIM
    } estado_t;

endpackage

// File: rtl/contador_eixo.sv
// Single-axis step counter: advances by passo on incr and wraps to zero once the
// next step would reach or pass the limit, which it flags through ultimo.
module contador_eixo
    import zoom_pkg::*;
#(
    parameter int W  = LARG_W_PADRAO,
    parameter int PW = PASSO_W_PADRAO
)
(
    input  logic          clock,
    input  logic          reset,
    input  logic          limpar,
    input  logic          incr,
    input  logic [PW-1:0] passo,
    input  logic [W-1:0]  limite,
    output logic [W-1:0]  cont,
    output logic          ultimo
);

    localparam int SW = W + 1;

    logic [W-1:0] cont_q;
    logic [W-1:0] cont_d;
    logic [W:0]   soma;

    // One extra bit keeps cont + passo from wrapping near the top of the range.
    always_comb begin
        soma   = {1'b0, cont_q} + SW'(passo);
        ultimo = (soma >= {1'b0, limite});
        cont_d = cont_q;
        if (limpar) begin
            cont_d = '0;
        end else if (incr) begin
            cont_d = ultimo ? '0 : soma[W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign cont = cont_q;

endmodule

// File: rtl/contador_varredura_2d.sv
// 2-D raster scan counter: latches frame geometry on iniciar, walks (cont_x, cont_y)
// with a programmable step, stalls on enable=0 and aborts on config_mudou.
module contador_varredura_2d
    import zoom_pkg::*;
#(
    parameter int LARG_W  = LARG_W_PADRAO,
    parameter int ALT_W   = ALT_W_PADRAO,
    parameter int PASSO_W = PASSO_W_PADRAO
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic               config_mudou,
    input  logic               iniciar,
    input  logic               enable,
    input  logic [LARG_W-1:0]  largura_max,
    input  logic [ALT_W-1:0]   altura_max,
    input  logic [PASSO_W-1:0] passo,
    output logic [LARG_W-1:0]  cont_x,
    output logic [ALT_W-1:0]   cont_y,
    output logic               ativo,
    output logic               fim_linha,
    output logic               fim_quadro,
    output logic               done
);

    estado_t              estado_q,    estado_d;
    logic [LARG_W-1:0]    larg_lat_q,  larg_lat_d;
    logic [ALT_W-1:0]     alt_lat_q,   alt_lat_d;
    logic [PASSO_W-1:0]   passo_lat_q, passo_lat_d;
    logic                 ativo_q,     ativo_d;
    logic                 done_q,      done_d;

    logic                 x_ultimo;
    logic                 y_ultimo;
    logic                 geom_nula;
    logic                 partida;
    logic                 avanca;

    assign geom_nula = (largura_max == '0) || (altura_max == '0) || (passo == '0);
    assign partida   = (estado_q == OCIOSO) && iniciar && !config_mudou;
    assign avanca    = ativo_q && enable;

    // config_mudou overrides every state, including a start on the same cycle.
    always_comb begin
        estado_d    = estado_q;
        larg_lat_d  = larg_lat_q;
        alt_lat_d   = alt_lat_q;
        passo_lat_d = passo_lat_q;
        done_d      = 1'b0;
        if (config_mudou) begin
            estado_d    = OCIOSO;
            larg_lat_d  = '0;
            alt_lat_d   = '0;
            passo_lat_d = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (iniciar) begin
                        larg_lat_d  = largura_max;
                        alt_lat_d   = altura_max;
                        passo_lat_d = passo;
                        estado_d    = geom_nula ? FIM : VARRENDO;
                    end
                end
                VARRENDO: begin
                    if (enable && fim_quadro) begin
                        estado_d = FIM;
                    end
                end
                FIM: begin
                    estado_d = OCIOSO;
                    done_d   = 1'b1;
                end
                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end
        ativo_d = (estado_d == VARRENDO);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            larg_lat_q  <= '0;
            alt_lat_q   <= '0;
            passo_lat_q <= '0;
            ativo_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            larg_lat_q  <= larg_lat_d;
            alt_lat_q   <= alt_lat_d;
            passo_lat_q <= passo_lat_d;
            ativo_q     <= ativo_d;
            done_q      <= done_d;
        end
    end

    // The x axis wraps on its own last column; y only moves when x wraps.
    contador_eixo #(
        .W  (LARG_W),
        .PW (PASSO_W)
    ) u_eixo_x (
        .clock  (clock),
        .reset  (reset),
        .limpar (config_mudou || partida),
        .incr   (avanca),
        .passo  (passo_lat_q),
        .limite (larg_lat_q),
        .cont   (cont_x),
        .ultimo (x_ultimo)
    );

    contador_eixo #(
        .W  (ALT_W),
        .PW (PASSO_W)
    ) u_eixo_y (
        .clock  (clock),
        .reset  (reset),
        .limpar (config_mudou || partida),
        .incr   (avanca && x_ultimo),
        .passo  (passo_lat_q),
        .limite (alt_lat_q),
        .cont   (cont_y),
        .ultimo (y_ultimo)
    );

    assign ativo      = ativo_q;
    assign done       = done_q;
    assign fim_linha  = ativo_q && x_ultimo;
    assign fim_quadro = fim_linha && y_ultimo;

endmodule
